// File: rtl/heap_decode.sv
// Decode/issue stage for the custom heap push/pop instructions: register file,
// pending-write scoreboard and a one-entry registered output bundle toward execute.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready never depends on in_valid, and out_valid, once raised, stays
// high with a stable bundle until out_ready is seen.
module heap_decode #(
  parameter int          DATA_W     = 32,
  parameter logic [6:0]  CUSTOM_OPC = 7'b0001011
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  output logic              in_ready,
  input  logic              wb_en,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] rs1_val,
  output logic [DATA_W-1:0] rs2_val,
  output logic [4:0]        rd,
  output logic              custom_push_heap,
  output logic              custom_pop_heap,
  output logic              out_illegal,
  output logic              dbg_state
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_rf [32];
  logic [31:0]       r_pend;
  logic [31:0]       w_pend_set;
  logic [31:0]       w_pend_clr;
  logic [31:0]       w_pend_nxt;

  logic [DATA_W-1:0] r_rs1_val;
  logic [DATA_W-1:0] r_rs2_val;
  logic [4:0]        r_rd;
  logic              r_push;
  logic              r_pop;
  logic              r_illegal;

  logic [6:0]        w_opcode;
  logic [4:0]        w_rd;
  logic [2:0]        w_funct3;
  logic [4:0]        w_rs1;
  logic [4:0]        w_rs2;
  logic [6:0]        w_funct7;
  logic              w_is_push;
  logic              w_is_pop;
  logic              w_is_op;
  logic              w_use_rs1;
  logic              w_use_rs2;
  logic [DATA_W-1:0] w_rs1_rd;
  logic [DATA_W-1:0] w_rs2_rd;
  logic              w_haz_rs1;
  logic              w_haz_rs2;
  logic              w_hazard;
  logic              w_accept;

  // Field extraction and op decode
  assign w_opcode  = in_instr[6:0];
  assign w_rd      = in_instr[11:7];
  assign w_funct3  = in_instr[14:12];
  assign w_rs1     = in_instr[19:15];
  assign w_rs2     = in_instr[24:20];
  assign w_funct7  = in_instr[31:25];

  assign w_is_push = (w_opcode == CUSTOM_OPC) && (w_funct3 == 3'b000) && (w_funct7 == 7'd0);
  assign w_is_pop  = (w_opcode == CUSTOM_OPC) && (w_funct3 == 3'b001) && (w_funct7 == 7'd0);
  assign w_is_op   = w_is_push || w_is_pop;
  assign w_use_rs1 = w_is_op;
  assign w_use_rs2 = w_is_push;

  // Register read with same-cycle writeback bypass; x0 is hardwired to zero.
  always_comb begin
    w_rs1_rd = '0;
    w_rs2_rd = '0;
    if (w_rs1 != 5'd0) begin
      if (wb_en && (wb_rd == w_rs1)) w_rs1_rd = wb_data;
      else                           w_rs1_rd = r_rf[w_rs1];
    end
    if (w_rs2 != 5'd0) begin
      if (wb_en && (wb_rd == w_rs2)) w_rs2_rd = wb_data;
      else                           w_rs2_rd = r_rf[w_rs2];
    end
  end

  // A source waiting on a writeback stalls unless that writeback lands this cycle.
  assign w_haz_rs1 = w_use_rs1 && (w_rs1 != 5'd0) && r_pend[w_rs1] &&
                     !(wb_en && (wb_rd == w_rs1));
  assign w_haz_rs2 = w_use_rs2 && (w_rs2 != 5'd0) && r_pend[w_rs2] &&
                     !(wb_en && (wb_rd == w_rs2));
  assign w_hazard  = w_haz_rs1 || w_haz_rs2;

  assign in_ready  = ((r_state == ST_EMPTY) || out_ready) && !w_hazard;
  assign w_accept  = in_valid && in_ready;

  // Scoreboard update: a new pending set overrides a same-index retire.
  always_comb begin
    w_pend_clr = '0;
    w_pend_set = '0;
    if (wb_en) w_pend_clr[wb_rd] = 1'b1;
    if (w_accept && w_is_op && (w_rd != 5'd0)) w_pend_set[w_rd] = 1'b1;
    w_pend_nxt = ((r_pend & ~w_pend_clr) | w_pend_set) & 32'hFFFF_FFFE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (wb_en && (wb_rd != 5'd0)) begin
      r_rf[wb_rd] <= wb_data;
    end
  end

  // Output FSM
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL: begin
        if (w_accept)       w_state_nxt = ST_FULL;
        else if (out_ready) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Bundle registers only move on accept, so they hold through back-pressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_rd      <= '0;
      r_push    <= 1'b0;
      r_pop     <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_rs1_val <= w_use_rs1 ? w_rs1_rd : '0;
      r_rs2_val <= w_use_rs2 ? w_rs2_rd : '0;
      r_rd      <= w_rd;
      r_push    <= w_is_push;
      r_pop     <= w_is_pop;
      r_illegal <= !w_is_op;
    end
  end

  assign out_valid        = (r_state == ST_FULL);
  assign rs1_val          = r_rs1_val;
  assign rs2_val          = r_rs2_val;
  assign rd               = r_rd;
  assign custom_push_heap = r_push;
  assign custom_pop_heap  = r_pop;
  assign out_illegal      = r_illegal;
  assign dbg_state        = r_state;

endmodule
